fifo_stream_reader: RTL and testbench

- Read-side master for the team's synchronous FIFO, which has 1-cycle registered read data and a `valid` pulse.
- Drains the FIFO and presents words as a valid/ready stream to the CNN datapath (line/window buffers).
- Hides the FIFO read latency with a 2-entry output buffer, sustaining 1 word/cycle.
- Counts words per frame (one feature-map row) to generate `m_last` and a `frame_done` pulse.

---
 rtl/cnn_stream_pkg.sv | 15 +
 rtl/fifo_stream_reader_if.sv | 27 ++
 rtl/fifo_stream_reader_skid_buf2.sv | 82 ++++++++
 rtl/fifo_stream_reader.sv | 79 +++++++
 tb/tb_fifo_stream_reader.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cnn_stream_pkg.sv
// Shared constants and types for the CNN stream read path.
package cnn_stream_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 16;
  localparam int unsigned DEFAULT_FRAME_LEN  = 28;
  localparam int unsigned SKID_DEPTH         = 2;

  // Output buffer occupancy (head + skid register)
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

endpackage

// File: rtl/fifo_stream_reader_if.sv
// Valid/ready stream toward the CNN datapath, with end-of-frame marker.
interface fifo_stream_reader_if
  import cnn_stream_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) ();

  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;
  logic                  m_last;

  modport master (
    output m_data,
    output m_valid,
    output m_last,
    input  m_ready
  );

  modport slave (
    input  m_data,
    input  m_valid,
    input  m_last,
    output m_ready
  );

endinterface

// File: rtl/fifo_stream_reader_skid_buf2.sv
// Two-entry output buffer: head register drives the stream, skid register
// absorbs the word that arrives while the head is stalled.
module skid_buf2
  import cnn_stream_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  valid,
  output occ_e                  occ,
  output logic                  drop_c
);

  logic [DATA_WIDTH-1:0] skid_q;
  logic [DATA_WIDTH-1:0] head_nxt;
  logic [DATA_WIDTH-1:0] skid_nxt;
  occ_e                  occ_nxt;
  logic                  pop_ok;

  // Next-state for head/skid/occupancy; a push into a full buffer is dropped
  always_comb begin
    head_nxt = data;
    skid_nxt = skid_q;
    occ_nxt  = occ;
    drop_c   = 1'b0;
    pop_ok   = pop & (occ != OCC_EMPTY);
    case ({push, pop_ok})
      2'b10: begin
        case (occ)
          OCC_EMPTY: begin
            head_nxt = push_data;
            occ_nxt  = OCC_ONE;
          end
          OCC_ONE: begin
            skid_nxt = push_data;
            occ_nxt  = OCC_FULL;
          end
          default: drop_c = 1'b1;
        endcase
      end
      2'b01: begin
        if (occ == OCC_FULL) begin
          head_nxt = skid_q;
          occ_nxt  = OCC_ONE;
        end else begin
          occ_nxt  = OCC_EMPTY;
        end
      end
      2'b11: begin
        // occupancy unchanged, head advances
        if (occ == OCC_FULL) begin
          head_nxt = skid_q;
          skid_nxt = push_data;
        end else begin
          head_nxt = push_data;
        end
      end
      default: ;
    endcase
  end

  // Buffer registers; valid is registered alongside occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      data   <= '0;
      skid_q <= '0;
      occ    <= OCC_EMPTY;
      valid  <= 1'b0;
    end else begin
      data   <= head_nxt;
      skid_q <= skid_nxt;
      occ    <= occ_nxt;
      valid  <= (occ_nxt != OCC_EMPTY);
    end
  end

endmodule

// File: rtl/fifo_stream_reader.sv
// Read-side master for the synchronous FIFO: issues reads, hides the
// one-cycle read latency behind a 2-entry buffer, and frames the stream.
module fifo_stream_reader
  import cnn_stream_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned FRAME_LEN  = DEFAULT_FRAME_LEN,
  parameter int unsigned CNT_WIDTH  = $clog2(FRAME_LEN + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   fifo_empty,
  output logic                   fifo_rd_en,
  input  logic [DATA_WIDTH-1:0]  fifo_rd_data,
  input  logic                   fifo_valid,
  fifo_stream_reader_if.master   m,
  output logic                   frame_done,
  output logic                   ovf_err
);

  localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(FRAME_LEN - 1);

  logic                  inflight;
  logic                  pop;
  logic                  capture;
  logic                  buf_valid;
  logic [DATA_WIDTH-1:0] buf_data;
  occ_e                  occ;
  logic                  drop_c;
  logic [2:0]            occ_sum;
  logic [CNT_WIDTH-1:0]  word_cnt;
  logic                  at_last;

  assign pop     = buf_valid & m.m_ready;
  assign capture = fifo_valid & inflight;
  assign at_last = (word_cnt == LAST_IDX);

  // Projected occupancy next cycle; pop implies occ >= 1 so no underflow
  assign occ_sum    = {1'b0, occ} + 3'(inflight) - 3'(pop);
  assign fifo_rd_en = en & ~fifo_empty & ~rst & (occ_sum < 3'(SKID_DEPTH));

  // Stream outputs come straight from the buffer head
  assign m.m_data  = buf_data;
  assign m.m_valid = buf_valid;
  assign m.m_last  = buf_valid & at_last;

  skid_buf2 #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (capture),
    .push_data (fifo_rd_data),
    .pop       (pop),
    .data      (buf_data),
    .valid     (buf_valid),
    .occ       (occ),
    .drop_c    (drop_c)
  );

  // In-flight tracking, frame position, end-of-frame pulse, sticky overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight   <= 1'b0;
      word_cnt   <= '0;
      frame_done <= 1'b0;
      ovf_err    <= 1'b0;
    end else begin
      inflight   <= fifo_rd_en;
      frame_done <= pop & at_last;
      ovf_err    <= ovf_err | drop_c;
      if (pop) begin
        word_cnt <= at_last ? '0 : word_cnt + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Self-checking bench: FIFO model + scoreboard for FRAME_LEN=28 and FRAME_LEN=1.
module tb_fifo_stream_reader;
  import cnn_stream_pkg::*;

  localparam int unsigned DW = 16;
  localparam int unsigned FL = 28;

  logic clk;
  logic rst, en, fifo_empty, fifo_valid, fifo_rd_en, frame_done, ovf_err;
  logic [DW-1:0] fifo_rd_data;
  logic en1, fifo_empty1, fifo_valid1, fifo_rd_en1, frame_done1, ovf_err1;
  logic [DW-1:0] fifo_rd_data1;

  fifo_stream_reader_if #(.DATA_WIDTH(DW)) bus ();
  fifo_stream_reader_if #(.DATA_WIDTH(DW)) bus1 ();

  fifo_stream_reader #(.DATA_WIDTH(DW), .FRAME_LEN(FL)) dut (
    .clk(clk), .rst(rst), .en(en), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
    .fifo_rd_data(fifo_rd_data), .fifo_valid(fifo_valid), .m(bus.master),
    .frame_done(frame_done), .ovf_err(ovf_err)
  );

  fifo_stream_reader #(.DATA_WIDTH(DW), .FRAME_LEN(1)) dut1 (
    .clk(clk), .rst(rst), .en(en1), .fifo_empty(fifo_empty1), .fifo_rd_en(fifo_rd_en1),
    .fifo_rd_data(fifo_rd_data1), .fifo_valid(fifo_valid1), .m(bus1.master),
    .frame_done(frame_done1), .ovf_err(ovf_err1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  logic [DW-1:0] fifo_q[$], exp_q[$], fifo1_q[$], exp1_q[$];
  int  widx = 0, pops = 0, lasts = 0, fdones = 0, cyc = 0;
  int  pops1 = 0, lasts1 = 0, fdones1 = 0;
  bit  fd_exp = 0, fd1_exp = 0, inject_stray = 0, dut1_on = 0;
  bit  s_rd, s_valid, s_last, s_pop;
  logic [DW-1:0] s_data, last_word;

  typedef struct {
    bit            rdy;
    bit            rd;
    bit            vld;
    logic [DW-1:0] data;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
  endtask

  task automatic fail_now(input string name, input logic [31:0] got);
    checks++;
    $display("FAIL %s: got 0x%0h expected no word (cycle %0d)", name, got, cyc);
  endtask

  task automatic push_word(input logic [DW-1:0] w);
    fifo_q.push_back(w);
    fifo_empty = 1'b0;
  endtask

  task automatic push_word1(input logic [DW-1:0] w);
    fifo1_q.push_back(w);
    fifo_empty1 = 1'b0;
  endtask

  // One clock: sample/score at negedge, then model the FIFO read response
  task automatic tick();
    bit rd, rd1;
    logic [DW-1:0] e;
    @(negedge clk);
    cyc++;
    rd      = fifo_rd_en;
    rd1     = fifo_rd_en1;
    s_rd    = fifo_rd_en;
    s_valid = bus.m_valid;
    s_data  = bus.m_data;
    s_last  = bus.m_last;
    s_pop   = bus.m_valid & bus.m_ready & ~rst;
    check("frame_done", frame_done, fd_exp);
    if (frame_done) fdones++;
    if (dut1_on) check("fl1_frame_done", frame_done1, fd1_exp);
    if (rst) begin
      exp_q.delete(); exp1_q.delete();
      widx = 0; fd_exp = 0; fd1_exp = 0;
    end else begin
      fd_exp = 0;
      if (s_pop) begin
        if (exp_q.size() == 0) fail_now("spurious_word", s_data);
        else begin
          e = exp_q.pop_front();
          check("m_data", s_data, e);
          check("m_last", s_last, widx == FL - 1);
          fd_exp = (widx == FL - 1);
          widx = (widx == FL - 1) ? 0 : widx + 1;
          pops++;
          if (s_last) begin lasts++; last_word = s_data; end
        end
      end
      fd1_exp = 0;
      if (bus1.m_valid & bus1.m_ready) begin
        if (exp1_q.size() == 0) fail_now("fl1_spurious_word", bus1.m_data);
        else begin
          e = exp1_q.pop_front();
          check("fl1_m_data", bus1.m_data, e);
          check("fl1_m_last", bus1.m_last, 1'b1);
          fd1_exp = 1;
          pops1++;
          if (bus1.m_last) lasts1++;
        end
      end
      if (frame_done1) fdones1++;
    end
    @(posedge clk);
    #1;
    if (rd && fifo_q.size() == 0) begin
      fail_now("rd_when_empty", 0);
      fifo_valid = 1'b0;
    end else if (rd) begin
      fifo_valid   = 1'b1;
      fifo_rd_data = fifo_q.pop_front();
      exp_q.push_back(fifo_rd_data);
    end else if (inject_stray) begin
      fifo_valid   = 1'b1;
      fifo_rd_data = 16'hDEAD;
      inject_stray = 0;
    end else begin
      fifo_valid = 1'b0;
    end
    fifo_empty = (fifo_q.size() == 0);
    if (rd1 && fifo1_q.size() == 0) begin
      fail_now("fl1_rd_when_empty", 0);
      fifo_valid1 = 1'b0;
    end else if (rd1) begin
      fifo_valid1   = 1'b1;
      fifo_rd_data1 = fifo1_q.pop_front();
      exp1_q.push_back(fifo_rd_data1);
    end else begin
      fifo_valid1 = 1'b0;
    end
    fifo_empty1 = (fifo1_q.size() == 0);
    #1;
  endtask

  task automatic reset_all();
    rst = 1'b1; en = 1'b0; en1 = 1'b0;
    bus.m_ready = 1'b0; bus1.m_ready = 1'b0;
    fifo_q.delete(); fifo1_q.delete();
    fifo_empty = 1'b1; fifo_empty1 = 1'b1; inject_stray = 0;
    tick(); tick();
    rst = 1'b0;
    pops = 0; lasts = 0; fdones = 0; pops1 = 0; lasts1 = 0; fdones1 = 0;
  endtask

  initial begin
    vec_t bp[19];
    int guard, rd_cnt, first_rd, last_rd, first_pop, last_pop, written;

    bp = '{'{0,1,0,0}, '{0,1,0,0}, '{0,0,1,1}, '{0,0,1,1}, '{0,0,1,1},
           '{0,0,1,1}, '{0,0,1,1}, '{0,0,1,1}, '{1,1,1,1}, '{1,1,1,2},
           '{1,1,1,3}, '{1,1,1,4}, '{1,1,1,5}, '{1,1,1,6}, '{1,1,1,7},
           '{1,1,1,8}, '{1,0,1,9}, '{1,0,1,10}, '{1,0,0,0}};

    rst = 1'b1; en = 1'b0; en1 = 1'b0;
    bus.m_ready = 1'b0; bus1.m_ready = 1'b0;
    fifo_valid = 1'b0; fifo_valid1 = 1'b0;
    fifo_rd_data = '0; fifo_rd_data1 = '0;
    fifo_empty = 1'b1; fifo_empty1 = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Reset state: no read while rst even with data available
    push_word(16'h0055); en = 1'b1; bus.m_ready = 1'b1;
    #1;
    check("rst_rd_en", fifo_rd_en, 0);
    check("rst_m_valid", bus.m_valid, 0);
    check("rst_m_last", bus.m_last, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_ovf_err", ovf_err, 0);
    check("rst_m_data", bus.m_data, 0);
    reset_all();

    // Backpressure: 10 words, ready low for 8 cycles
    for (int i = 1; i <= 10; i++) push_word(DW'(i));
    en = 1'b1;
    for (int i = 0; i < 19; i++) begin
      bus.m_ready = bp[i].rdy;
      tick();
      check("bp_rd_en", s_rd, bp[i].rd);
      check("bp_m_valid", s_valid, bp[i].vld);
      if (bp[i].vld) check("bp_m_data", s_data, bp[i].data);
    end
    check("bp_words", pops, 10);
    check("bp_ovf_err", ovf_err, 0);

    // Back-to-back drain of one full frame
    reset_all();
    for (int i = 1; i <= 28; i++) push_word(DW'(i));
    en = 1'b1; bus.m_ready = 1'b1;
    rd_cnt = 0; first_rd = -1; last_rd = -1; first_pop = -1; last_pop = -1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (s_rd) begin
        rd_cnt++;
        if (first_rd < 0) first_rd = cyc;
        last_rd = cyc;
      end
      if (s_pop) begin
        if (first_pop < 0) first_pop = cyc;
        last_pop = cyc;
      end
    end
    check("drain_rd_count", rd_cnt, 28);
    check("drain_rd_span", last_rd - first_rd, 27);
    check("drain_latency", first_pop - first_rd, 2);
    check("drain_pop_span", last_pop - first_pop, 27);
    check("drain_words", pops, 28);
    check("drain_lasts", lasts, 1);
    check("drain_last_word", last_word, 16'h001C);
    check("drain_frame_done", fdones, 1);

    // Random ready and random FIFO writes, 1000 words
    reset_all();
    en = 1'b1; written = 0; guard = 0;
    while (pops < 1000 && guard < 20000) begin
      bus.m_ready = 1'($urandom_range(0, 1));
      if (written < 1000 && $urandom_range(0, 1) == 1) begin
        written++;
        push_word(DW'(written));
      end
      tick();
      guard++;
    end
    check("rnd_words", pops, 1000);
    check("rnd_lasts", lasts, 35);
    check("rnd_ovf_err", ovf_err, 0);

    // FIFO runs dry after 13 words, refilled 5 cycles later
    reset_all();
    en = 1'b1; bus.m_ready = 1'b1;
    for (int i = 1; i <= 13; i++) push_word(DW'(i));
    guard = 0;
    while (pops < 13 && guard < 100) begin tick(); guard++; end
    check("empty_first_part", pops, 13);
    repeat (5) tick();
    for (int i = 14; i <= 28; i++) push_word(DW'(i));
    guard = 0;
    while (pops < 28 && guard < 100) begin tick(); guard++; end
    tick(); tick();
    check("empty_words", pops, 28);
    check("empty_lasts", lasts, 1);
    check("empty_last_word", last_word, 16'h001C);
    check("empty_frame_done", fdones, 1);

    // en drops with two reads outstanding
    reset_all();
    for (int i = 1; i <= 10; i++) push_word(DW'(i));
    en = 1'b1; bus.m_ready = 1'b0;
    tick(); tick();
    en = 1'b0; rd_cnt = 0;
    for (int i = 0; i < 4; i++) begin tick(); if (s_rd) rd_cnt++; end
    bus.m_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin tick(); if (s_rd) rd_cnt++; end
    check("en0_no_read", rd_cnt, 0);
    check("en0_delivered", pops, 2);
    en = 1'b1; guard = 0;
    while (pops < 10 && guard < 100) begin tick(); guard++; end
    check("en0_rest", pops, 10);

    // Reset in the middle of a frame, with a stray valid afterwards
    reset_all();
    for (int i = 1; i <= 40; i++) push_word(DW'(i));
    en = 1'b1; bus.m_ready = 1'b1; guard = 0;
    while (pops < 15 && guard < 100) begin tick(); guard++; end
    check("mid_reached_15", pops, 15);
    check("mid_rd_before_rst", s_rd, 1);
    rst = 1'b1; inject_stray = 1;
    tick();
    rst = 1'b0;
    tick();
    check("mid_m_valid_after_rst", s_valid, 0);
    check("mid_m_last_after_rst", s_last, 0);
    pops = 0; lasts = 0; fdones = 0;
    for (int i = 41; i <= 80; i++) push_word(DW'(i));
    guard = 0;
    while (pops < 28 && guard < 200) begin tick(); guard++; end
    bus.m_ready = 1'b0;
    tick(); tick();
    check("mid_words", pops, 28);
    check("mid_lasts", lasts, 1);
    check("mid_frame_done", fdones, 1);
    check("mid_ovf_err", ovf_err, 0);

    // FRAME_LEN=1: every word is a frame
    reset_all();
    dut1_on = 1;
    for (int i = 1; i <= 5; i++) push_word1(DW'(16'h0100 + i));
    en1 = 1'b1; bus1.m_ready = 1'b1;
    repeat (12) tick();
    check("fl1_words", pops1, 5);
    check("fl1_lasts", lasts1, 5);
    check("fl1_frame_done", fdones1, 5);
    check("fl1_ovf_err", ovf_err1, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
